// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm annunciator.
package alarm_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned SIL_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_ALARM    = 2'd1,
    ST_SILENCED = 2'd2,
    ST_UNUSED   = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for asynchronous push-buttons.
//  clk      in  system clock
//  rst      in  synchronous, active-low reset
//  din      in  asynchronous level input
//  pulse_c  out one-cycle pulse on each synchronized rising edge
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse_c
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  // Synchronizer chain and previous-value register for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign pulse_c = sync_q2 & ~prev_q;

endmodule

// File: rtl/alarm_annunciator.sv
// Operator signalling for alarm levels: latched causes, blinking lamps, buzzer
// pattern, and timed buzzer silencing via the ack push-button.
//  clk          in  system clock
//  rst          in  synchronous, active-low reset
//  alarm_smoke  in  smoke alarm level (synchronous)
//  alarm_curr   in  overcurrent alarm level (synchronous)
//  ack          in  operator push-button (asynchronous, active-high)
//  buzzer       out buzzer drive
//  led_ok       out system-normal lamp
//  led_smoke    out smoke lamp
//  led_curr     out overcurrent lamp
//  silenced     out high while buzzer is silenced
//  state_o      out current state code (debug)
module alarm_annunciator
  import alarm_pkg::*;
#(
  parameter int unsigned BLINK_DIV     = 25_000_000,
  parameter int unsigned SILENCE_TICKS = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alarm_smoke,
  input  logic               alarm_curr,
  input  logic               ack,
  output logic               buzzer,
  output logic               led_ok,
  output logic               led_smoke,
  output logic               led_curr,
  output logic               silenced,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned PRE_W = $clog2(BLINK_DIV);

  logic [PRE_W-1:0]     pre_cnt;
  logic                 phase;
  logic                 tick_c;
  logic                 ack_pulse_c;
  logic                 flag_smoke;
  logic                 flag_curr;
  logic                 new_flag_c;
  logic                 inputs_low_c;
  state_t               state;
  state_t               state_next;
  logic [SIL_CNT_W-1:0] sil_cnt;
  logic [SIL_CNT_W-1:0] sil_cnt_next;

  sync_edge u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .din     (ack),
    .pulse_c (ack_pulse_c)
  );

  // Blink prescaler: free-running, phase flips once per half-period.
  assign tick_c = (pre_cnt == PRE_W'(BLINK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt <= '0;
      phase   <= 1'b0;
    end else if (tick_c) begin
      pre_cnt <= '0;
      phase   <= ~phase;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Cause latches: a high input always wins over an ack clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flag_smoke <= 1'b0;
      flag_curr  <= 1'b0;
    end else begin
      flag_smoke <= alarm_smoke | (flag_smoke & ~ack_pulse_c);
      flag_curr  <= alarm_curr  | (flag_curr  & ~ack_pulse_c);
    end
  end

  // A flag that is about to go 0 -> 1 this edge.
  assign new_flag_c   = (alarm_smoke & ~flag_smoke) | (alarm_curr & ~flag_curr);
  assign inputs_low_c = ~alarm_smoke & ~alarm_curr;

  // State and silence-counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      sil_cnt <= '0;
    end else begin
      state   <= state_next;
      sil_cnt <= sil_cnt_next;
    end
  end

  // Next-state, silence counter and output decode.
  always_comb begin
    state_next   = state;
    sil_cnt_next = sil_cnt;
    buzzer       = 1'b0;
    led_ok       = 1'b0;
    led_smoke    = 1'b0;
    led_curr     = 1'b0;
    silenced     = 1'b0;

    case (state)
      ST_IDLE: begin
        led_ok = 1'b1;
        if (flag_smoke || flag_curr) begin
          state_next = ST_ALARM;
        end
      end

      ST_ALARM: begin
        led_smoke = flag_smoke & phase;
        led_curr  = flag_curr & phase;
        buzzer    = flag_curr | phase;
        // A cause arriving together with the ack keeps the alarm sounding.
        if (ack_pulse_c && !new_flag_c) begin
          if (inputs_low_c) begin
            state_next = ST_IDLE;
          end else begin
            state_next   = ST_SILENCED;
            sil_cnt_next = SIL_CNT_W'(SILENCE_TICKS);
          end
        end
      end

      ST_SILENCED: begin
        led_smoke = flag_smoke;
        led_curr  = flag_curr;
        silenced  = 1'b1;
        if (new_flag_c) begin
          state_next   = ST_ALARM;
          sil_cnt_next = '0;
        end else if (ack_pulse_c && inputs_low_c) begin
          state_next   = ST_IDLE;
          sil_cnt_next = '0;
        end else if (tick_c) begin
          // Saturating countdown; the last tick ends the silence window.
          if (sil_cnt <= SIL_CNT_W'(1)) begin
            sil_cnt_next = '0;
            state_next   = (flag_smoke || flag_curr) ? ST_ALARM : ST_IDLE;
          end else begin
            sil_cnt_next = sil_cnt - SIL_CNT_W'(1);
          end
        end
      end

      default: begin
        state_next   = ST_IDLE;
        sil_cnt_next = '0;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed bench for alarm_annunciator with a queue-based expected-output scoreboard.
module tb_alarm_annunciator;
  import alarm_pkg::*;

  localparam int unsigned BLINK_DIV     = 4;
  localparam int unsigned SILENCE_TICKS = 3;

  logic       clk;
  logic       rst;
  logic       alarm_smoke;
  logic       alarm_curr;
  logic       ack;
  logic       buzzer;
  logic       led_ok;
  logic       led_smoke;
  logic       led_curr;
  logic       silenced;
  logic [1:0] state_o;

  typedef struct {
    string      tag;
    logic [6:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned k        = 0;
  int          ticks;
  bit          t;

  alarm_annunciator #(
    .BLINK_DIV     (BLINK_DIV),
    .SILENCE_TICKS (SILENCE_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alarm_smoke (alarm_smoke),
    .alarm_curr  (alarm_curr),
    .ack         (ack),
    .buzzer      (buzzer),
    .led_ok      (led_ok),
    .led_smoke   (led_smoke),
    .led_curr    (led_curr),
    .silenced    (silenced),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; gives the expected blink phase.
  always @(posedge clk) k <= rst ? k + 1 : 0;

  // Expected {state_o, buzzer, led_ok, led_smoke, led_curr, silenced}.
  function automatic logic [6:0] model(input logic [1:0] st, input logic fs,
                                       input logic fc, input logic ph);
    case (st)
      2'd0:    model = {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      2'd1:    model = {2'd1, fc | ph, 1'b0, fs & ph, fc & ph, 1'b0};
      2'd2:    model = {2'd2, 1'b0, 1'b0, fs, fc, 1'b1};
      default: model = {st, 5'b0};
    endcase
  endfunction

  task automatic check_pop();
    exp_t       e;
    logic [6:0] obs;
    obs = {state_o, buzzer, led_ok, led_smoke, led_curr, silenced};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty got=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s got=%0h exp=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Push the expectation for the coming edge, clock it, then compare.
  task automatic cyc(input string tag, input logic [1:0] st, input logic fs, input logic fc);
    int unsigned kn;
    kn = rst ? k + 1 : 0;
    sb.push_back('{tag, model(st, fs, fc, ((kn / BLINK_DIV) % 2) == 1)});
    @(posedge clk);
    @(negedge clk);
    check_pop();
  endtask

  // ack press: two synchronizer edges, state change on the third.
  task automatic ack_press(input string tag, input logic [1:0] st0, input logic fs0,
                           input logic fc0, input logic [1:0] st1, input logic fs1,
                           input logic fc1);
    ack = 1'b1;
    cyc({tag, "_sync1"}, st0, fs0, fc0);
    cyc({tag, "_sync2"}, st0, fs0, fc0);
    cyc(tag, st1, fs1, fc1);
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; alarm_smoke = 1'b0; alarm_curr = 1'b0; ack = 1'b0;

    // Reset hold and release.
    repeat (3) cyc("rst_hold", 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) cyc("rst_release", 2'd0, 1'b0, 1'b0);

    // One-cycle smoke pulse latches and blinks.
    alarm_smoke = 1'b1;
    cyc("smoke_flag", 2'd0, 1'b0, 1'b0);
    alarm_smoke = 1'b0;
    cyc("smoke_alarm", 2'd1, 1'b1, 1'b0);
    repeat (9) cyc("smoke_blink", 2'd1, 1'b1, 1'b0);
    ack_press("smoke_clear", 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

    // Overcurrent: steady buzzer, silence, timeout back to ALARM.
    alarm_curr = 1'b1;
    cyc("curr_flag", 2'd0, 1'b0, 1'b0);
    cyc("curr_alarm", 2'd1, 1'b0, 1'b1);
    repeat (5) cyc("curr_buzz", 2'd1, 1'b0, 1'b1);
    ack_press("curr_silence", 2'd1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    ticks = 0;
    for (int i = 0; i < 14; i++) begin
      if (((k + 1) % BLINK_DIV) == 0) ticks++;
      cyc("sil_timeout", (ticks >= int'(SILENCE_TICKS)) ? 2'd1 : 2'd2, 1'b0, 1'b1);
    end

    // New cause during silence re-arms immediately.
    ack_press("curr_silence2", 2'd1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    alarm_smoke = 1'b1;
    cyc("smoke_in_sil", 2'd1, 1'b1, 1'b1);
    repeat (4) cyc("both_alarm", 2'd1, 1'b1, 1'b1);

    // Inputs low then ack clears everything.
    alarm_smoke = 1'b0; alarm_curr = 1'b0;
    cyc("inputs_low", 2'd1, 1'b1, 1'b1);
    ack_press("full_clear", 2'd1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    repeat (3) cyc("idle_hold", 2'd0, 1'b0, 1'b0);

    // ack coinciding with a new overcurrent input stays in ALARM.
    alarm_smoke = 1'b1;
    cyc("smoke2_flag", 2'd0, 1'b0, 1'b0);
    cyc("smoke2_alarm", 2'd1, 1'b1, 1'b0);
    ack = 1'b1;
    cyc("race_sync1", 2'd1, 1'b1, 1'b0);
    cyc("race_sync2", 2'd1, 1'b1, 1'b0);
    alarm_curr = 1'b1;
    cyc("ack_vs_new", 2'd1, 1'b1, 1'b1);
    ack = 1'b0;
    cyc("ack_vs_new_hold", 2'd1, 1'b1, 1'b1);

    // Reset during SILENCED with the counter part-way down.
    ack_press("silence3", 2'd1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      t = (((k + 1) % BLINK_DIV) == 0);
      cyc("sil_wait_tick", 2'd2, 1'b1, 1'b1);
      if (t) break;
    end
    rst = 1'b0; alarm_smoke = 1'b0; alarm_curr = 1'b0;
    cyc("rst_in_sil", 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) cyc("post_rst_idle", 2'd0, 1'b0, 1'b0);

    // Unused state code recovers to IDLE on the next edge.
    force dut.state = ST_UNUSED;
    #1;
    sb.push_back('{"forced_unused", model(2'd3, 1'b0, 1'b0, 1'b0)});
    check_pop();
    release dut.state;
    cyc("unused_recover", 2'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
